// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa cell, LSB-first, one bit per clock, done pulse on completion.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow output OVF.

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             C_out,
  output logic             OVF
`else
  output logic             C_out
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fa u_fa (
    .a  (ra[0]),
    .b  (rb[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at S[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= A;
            rb  <= B;
            cy  <= C_in;
            cnt <= '0;
            S   <= '0;
          end
        end
        SHIFT: begin
          S   <= {fa_s, S[WIDTH-1:1]};
          cy  <= fa_c;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            C_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            OVF   <= cy ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8), plus hand-written
// sequences for held start, mid-add operand changes and asynchronous reset.

module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int unsigned passed;
  int unsigned total;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .C_in  (c_in),
    .busy  (busy),
    .done  (done),
    .S     (s),
`ifdef SERIAL_ADDER_OVF_EN
    .C_out (c_out),
    .OVF   (ovf)
`else
    .C_out (c_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive operands on the falling edge, assert start for exactly one rising edge.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    @(negedge clk);
    a     = va;
    b     = vb;
    c_in  = vc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns edges until done and busy samples seen.
  task automatic wait_done(output logic got, output int unsigned lat,
                           output int unsigned busy_cnt, output logic overlap);
    got      = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  logic        got;
  logic        overlap;
  int unsigned lat;
  int unsigned bcnt;
  int unsigned done_seen;

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    c_in   = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'h3C, 8'h4D, 1'b1, 8'h8A, 1'b0, 1'b1};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_s", 32'(s), 32'd0);
    check("reset_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(got, lat, bcnt, overlap);
      check($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
      check($sformatf("v%0d_latency", i), lat, WIDTH);
      check($sformatf("v%0d_busy_cycles", i), bcnt, WIDTH);
      check($sformatf("v%0d_busy_done_overlap", i), 32'(overlap), 32'd0);
      check($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("v%0d_cout", i), 32'(c_out), 32'(vecs[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("v%0d_s_hold", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("v%0d_cout_hold", i), 32'(c_out), 32'(vecs[i].co));
    end

    // Start held high with operands changed after capture.
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a    = 8'hFF;
    b    = 8'hFF;
    c_in = 1'b1;
    wait_done(got, lat, bcnt, overlap);
    check("held_done_seen", 32'(got), 32'd1);
    check("held_latency", lat, WIDTH);
    check("held_s", 32'(s), 32'h46);
    check("held_cout", 32'(c_out), 32'd0);
    @(posedge clk);
    #1;
    check("held_ignored_in_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("held_accepted_from_idle", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(got, lat, bcnt, overlap);
    check("held2_done_seen", 32'(got), 32'd1);
    check("held2_s", 32'(s), 32'hFF);
    check("held2_cout", 32'(c_out), 32'd1);

    // Asynchronous reset four cycles into SHIFT; partial sum is nonzero at that point.
    launch(8'h0F, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_cout", 32'(c_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_activity", done_seen, 32'd0);

    launch(8'h5A, 8'h33, 1'b1);
    wait_done(got, lat, bcnt, overlap);
    check("post_abort_done_seen", 32'(got), 32'd1);
    check("post_abort_latency", lat, WIDTH);
    check("post_abort_s", 32'(s), 32'h8E);
    check("post_abort_cout", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("post_abort_ovf", 32'(ovf), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
